// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous RAM between video (read-only, top priority),
// CPU and DMA (round-robin). Define ROM_PROTECT_EN to suppress writes into the ROM window.
module mem_arbiter #(
    parameter int AW       = 16,
    parameter int DW       = 8,
    parameter int ROM_BITS = 2,
    parameter int ROM_PAGE = 0
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_vid_req,
    input  logic [AW-1:0] i_vid_addr,
    output logic          o_vid_ack,
    output logic [DW-1:0] o_vid_rdata,
    input  logic          i_cpu_req,
    input  logic          i_cpu_we,
    input  logic [AW-1:0] i_cpu_addr,
    input  logic [DW-1:0] i_cpu_wdata,
    output logic          o_cpu_ack,
    output logic [DW-1:0] o_cpu_rdata,
    input  logic          i_dma_req,
    input  logic          i_dma_we,
    input  logic [AW-1:0] i_dma_addr,
    input  logic [DW-1:0] i_dma_wdata,
    output logic          o_dma_ack,
    output logic [DW-1:0] o_dma_rdata,
    output logic [AW-1:0] o_mem_address,
    output logic [DW-1:0] o_mem_data,
    output logic          o_mem_wren,
    input  logic [DW-1:0] i_mem_q,
    output logic          o_rom_block
);
    localparam int NUM_REQ = 3;
    localparam logic [1:0] VID = 2'd0;
    localparam logic [1:0] CPU = 2'd1;
    localparam logic [1:0] DMA = 2'd2;
    localparam logic [ROM_BITS-1:0] ROM_TAG = ROM_BITS'(ROM_PAGE);

    typedef struct packed {
        logic          req;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    req_t [NUM_REQ-1:0] w_req;
    req_t               w_sel;
    logic [1:0]         w_idx;
    logic               w_rom_hit;
    logic               w_blk;

    state_t                     r_state;
    logic [1:0]                 r_gnt;
    logic                       r_rr_dma;
    logic                       r_blk;
    logic                       r_rom_block;
    logic [NUM_REQ-1:0]         r_ack;
    logic [NUM_REQ-1:0][DW-1:0] r_rdata;
    logic [AW-1:0]              r_mem_address;
    logic [DW-1:0]              r_mem_data;
    logic                       r_mem_wren;

    assign w_req[VID] = '{req: i_vid_req, we: 1'b0,     addr: i_vid_addr, wdata: '0};
    assign w_req[CPU] = '{req: i_cpu_req, we: i_cpu_we, addr: i_cpu_addr, wdata: i_cpu_wdata};
    assign w_req[DMA] = '{req: i_dma_req, we: i_dma_we, addr: i_dma_addr, wdata: i_dma_wdata};

    // Video always wins; CPU/DMA contention is settled by r_rr_dma (1 = DMA favoured).
    // When nothing requests, w_sel falls back to the idle CPU port, so w_sel.req doubles as "any".
    always_comb begin
        w_idx = CPU;
        if (w_req[VID].req)
            w_idx = VID;
        else if (w_req[CPU].req && w_req[DMA].req)
            w_idx = r_rr_dma ? DMA : CPU;
        else if (w_req[DMA].req)
            w_idx = DMA;

        w_sel = w_req[CPU];
        case (w_idx)
            VID:     w_sel = w_req[VID];
            DMA:     w_sel = w_req[DMA];
            default: w_sel = w_req[CPU];
        endcase
    end

    assign w_rom_hit = w_sel.we && (w_sel.addr[AW-1 -: ROM_BITS] == ROM_TAG);

`ifdef ROM_PROTECT_EN
    assign w_blk       = w_rom_hit;
    assign o_rom_block = r_rom_block;
`else
    logic w_unused_rom;
    assign w_blk        = 1'b0;
    assign o_rom_block  = 1'b0;
    assign w_unused_rom = w_rom_hit ^ r_rom_block;
`endif

    // Fixed four-clock access: IDLE launches, ISSUE lets the RAM sample, WAIT captures q, DONE acks.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_gnt         <= VID;
            r_rr_dma      <= 1'b0;
            r_blk         <= 1'b0;
            r_rom_block   <= 1'b0;
            r_ack         <= '0;
            r_rdata       <= '0;
            r_mem_address <= '0;
            r_mem_data    <= '0;
            r_mem_wren    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_sel.req) begin
                        r_gnt         <= w_idx;
                        r_mem_address <= w_sel.addr;
                        r_mem_data    <= w_sel.wdata;
                        r_mem_wren    <= w_sel.we & ~w_blk;
                        r_blk         <= w_blk;
                        if (w_idx == CPU)
                            r_rr_dma <= 1'b1;
                        else if (w_idx == DMA)
                            r_rr_dma <= 1'b0;
                        r_state <= S_ISSUE;
                    end else begin
                        r_mem_wren <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    r_mem_wren <= 1'b0;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (r_gnt == 2'(i)) begin
                            r_rdata[i] <= i_mem_q;
                            r_ack[i]   <= 1'b1;
                        end
                    end
                    r_rom_block <= r_blk;
                    r_state     <= S_DONE;
                end
                default: begin
                    r_ack       <= '0;
                    r_rom_block <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign o_vid_ack     = r_ack[VID];
    assign o_cpu_ack     = r_ack[CPU];
    assign o_dma_ack     = r_ack[DMA];
    assign o_vid_rdata   = r_rdata[VID];
    assign o_cpu_rdata   = r_rdata[CPU];
    assign o_dma_rdata   = r_rdata[DMA];
    assign o_mem_address = r_mem_address;
    assign o_mem_data    = r_mem_data;
    assign o_mem_wren    = r_mem_wren;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a RAM model and
// a transaction-level reference (grant order, latency, memory contents).
module tb_mem_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        vid_req, vid_ack;
    logic [15:0] vid_addr;
    logic [7:0]  vid_rdata;
    logic        cpu_req, cpu_we, cpu_ack;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        dma_req, dma_we, dma_ack;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata, dma_rdata;
    logic [15:0] mem_address;
    logic [7:0]  mem_data, mem_q;
    logic        mem_wren, rom_block;

    mem_arbiter #(.AW(16), .DW(8), .ROM_BITS(2), .ROM_PAGE(0)) dut (
        .i_clock(clk), .i_reset(rst),
        .i_vid_req(vid_req), .i_vid_addr(vid_addr), .o_vid_ack(vid_ack), .o_vid_rdata(vid_rdata),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
        .o_cpu_ack(cpu_ack), .o_cpu_rdata(cpu_rdata),
        .i_dma_req(dma_req), .i_dma_we(dma_we), .i_dma_addr(dma_addr), .i_dma_wdata(dma_wdata),
        .o_dma_ack(dma_ack), .o_dma_rdata(dma_rdata),
        .o_mem_address(mem_address), .o_mem_data(mem_data), .o_mem_wren(mem_wren),
        .i_mem_q(mem_q), .o_rom_block(rom_block)
    );

    // Power-up RAM contents: a fixed function of the address (0x4000 holds 0x5A).
    function automatic logic [7:0] init_val(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h1A;
    endfunction

    // Single-port synchronous RAM, one-cycle read latency, read-before-write.
    logic [7:0] ram    [0:65535];
    bit         ram_wr [0:65535];
    always @(posedge clk) begin
        mem_q <= ram_wr[mem_address] ? ram[mem_address] : init_val(mem_address);
        if (mem_wren) begin
            ram[mem_address]    <= mem_data;
            ram_wr[mem_address] <= 1'b1;
        end
    end

    // Bus monitor, sampled on the falling edge.
    int          cyc = 0;
    int          log_who[$];
    logic [7:0]  log_dat[$];
    int          log_cyc[$];
    int          wren_cnt = 0, wren_dbl = 0, rom_cnt = 0, rom_orphan = 0;
    logic [15:0] wren_addr;
    logic [7:0]  wren_data;
    logic        prev_wren = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (vid_ack) begin log_who.push_back(0); log_dat.push_back(vid_rdata); log_cyc.push_back(cyc); end
        if (cpu_ack) begin log_who.push_back(1); log_dat.push_back(cpu_rdata); log_cyc.push_back(cyc); end
        if (dma_ack) begin log_who.push_back(2); log_dat.push_back(dma_rdata); log_cyc.push_back(cyc); end
        if (mem_wren) begin
            wren_cnt  <= wren_cnt + 1;
            wren_addr <= mem_address;
            wren_data <= mem_data;
            if (prev_wren) wren_dbl <= wren_dbl + 1;
        end
        prev_wren <= mem_wren;
        if (rom_block) begin
            rom_cnt <= rom_cnt + 1;
            if (!(cpu_ack || dma_ack)) rom_orphan <= rom_orphan + 1;
        end
    end

    // Reference model: memory contents plus the round-robin preference (1 = DMA next).
    logic [7:0] ref_mem [logic [15:0]];
    bit         rr_dma_m = 1'b0;
    int         exp_who[$];
    logic [7:0] exp_dat[$];
    bit         exp_rd[$];

    function automatic logic [7:0] ref_rd(input logic [15:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_val(a);
    endfunction

    function automatic bit rom_hit(input logic [15:0] a);
`ifdef ROM_PROTECT_EN
        return a[15:14] == 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    int n_chk = 0, n_fail = 0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Serve the accesses in predicted order and record what each should return.
    task automatic serve(input int w);
        logic [15:0] a;
        logic        we;
        logic [7:0]  d;
        a = (w == 0) ? vid_addr : (w == 1) ? cpu_addr : dma_addr;
        we = (w == 0) ? 1'b0 : (w == 1) ? cpu_we : dma_we;
        d = (w == 1) ? cpu_wdata : dma_wdata;
        exp_who.push_back(w);
        exp_rd.push_back(!we);
        exp_dat.push_back(ref_rd(a));
        if (we && !rom_hit(a)) ref_mem[a] = d;
        if (w == 1) rr_dma_m = 1'b1;
        if (w == 2) rr_dma_m = 1'b0;
    endtask

    task automatic predict(input logic [2:0] mask);
        exp_who.delete(); exp_dat.delete(); exp_rd.delete();
        if (mask[0]) serve(0);
        if (mask[1] && mask[2]) begin
            if (rr_dma_m) begin serve(2); serve(1); end
            else          begin serve(1); serve(2); end
        end else if (mask[1]) serve(1);
        else if (mask[2]) serve(2);
    endtask

    // Raise the masked requests and drop each one after its ack (hold: drop all after n_exp acks).
    task automatic batch(input logic [2:0] mask, input bit hold, input int n_exp,
                         output int base, output int c0);
        bit dv, dc, dd;
        base = log_who.size();
        c0   = cyc;
        vid_req = mask[0]; cpu_req = mask[1]; dma_req = mask[2];
        for (int t = 0; t < 80; t++) begin
            @(negedge clk);
            dv = vid_ack; dc = cpu_ack; dd = dma_ack;
            @(posedge clk); #1;
            if (hold) begin
                if (log_who.size() - base >= n_exp) begin
                    vid_req = 1'b0; cpu_req = 1'b0; dma_req = 1'b0;
                end
            end else begin
                if (dv) vid_req = 1'b0;
                if (dc) cpu_req = 1'b0;
                if (dd) dma_req = 1'b0;
            end
            if (!(vid_req || cpu_req || dma_req)) break;
        end
        vid_req = 1'b0; cpu_req = 1'b0; dma_req = 1'b0;
        chk("ack_count", log_who.size() - base, n_exp);
    endtask

    task automatic check_batch(input string tag, input int base, input int c0);
        for (int k = 0; k < exp_who.size(); k++) begin
            if (base + k < log_who.size()) begin
                chk($sformatf("%s_who%0d", tag, k), log_who[base+k], exp_who[k]);
                chk($sformatf("%s_lat%0d", tag, k), log_cyc[base+k] - c0, 3 + 4*k);
                if (exp_rd[k]) chk($sformatf("%s_data%0d", tag, k), log_dat[base+k], exp_dat[k]);
            end
        end
    endtask

    task automatic run(input logic [2:0] mask, input string tag, output int base, output int c0);
        predict(mask);
        batch(mask, 1'b0, exp_who.size(), base, c0);
        check_batch(tag, base, c0);
    endtask

    function automatic logic [15:0] rnd_addr();
        logic [1:0] hi, lo;
        hi = 2'($urandom);
        lo = 2'($urandom);
        return {hi, 12'h0A5, lo};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b, c, w0, r0, o0, n0, exp_w, exp_r;
        bit first_cpu;
        rst = 1'b1;
        vid_req = 1'b0; cpu_req = 1'b0; dma_req = 1'b0;
        vid_addr = '0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_acks",  {vid_ack, cpu_ack, dma_ack}, 0);
        chk("rst_rdata", {vid_rdata, cpu_rdata, dma_rdata}, 0);
        chk("rst_mem",   {mem_address, mem_data, mem_wren, rom_block}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // All three at once: vid, cpu, dma, one access every 4 clocks.
        vid_addr = 16'h1234; cpu_addr = 16'h2345; dma_addr = 16'h3456;
        run(3'b111, "t3", b, c);
        chk("t3_order", {log_who[b], log_who[b+1], log_who[b+2]}, {32'd0, 32'd1, 32'd2});

        // CPU read of 0x4000.
        cpu_we = 1'b0; cpu_addr = 16'h4000;
        w0 = wren_cnt;
        run(3'b010, "t1", b, c);
        chk("t1_rdata", log_dat[b], 8'h5A);
        chk("t1_nowren", wren_cnt - w0, 0);

        // CPU write 0x8001 <- 0xC3, then read back.
        cpu_we = 1'b1; cpu_addr = 16'h8001; cpu_wdata = 8'hC3;
        w0 = wren_cnt;
        run(3'b010, "t2w", b, c);
        chk("t2_wren_pulses", wren_cnt - w0, 1);
        chk("t2_wren_addr", wren_addr, 16'h8001);
        chk("t2_wren_data", wren_data, 8'hC3);
        cpu_we = 1'b0;
        run(3'b010, "t2r", b, c);
        chk("t2_readback", log_dat[b], 8'hC3);

        // CPU and DMA held continuously: 8 strictly alternating grants.
        cpu_we = 1'b0; cpu_addr = 16'h5000; dma_we = 1'b0; dma_addr = 16'h6000;
        exp_who.delete(); exp_dat.delete(); exp_rd.delete();
        first_cpu = !rr_dma_m;
        for (int k = 0; k < 8; k++) begin
            exp_who.push_back(((k % 2 == 0) == first_cpu) ? 1 : 2);
            exp_rd.push_back(1'b1);
            exp_dat.push_back(ref_rd((exp_who[k] == 1) ? cpu_addr : dma_addr));
        end
        rr_dma_m = (exp_who[7] == 1);
        batch(3'b110, 1'b1, 8, b, c);
        check_batch("t4", b, c);

        // Write into the ROM window.
        cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 8'hFF;
        w0 = wren_cnt; r0 = rom_cnt; o0 = rom_orphan;
        run(3'b010, "t5w", b, c);
`ifdef ROM_PROTECT_EN
        exp_w = 0; exp_r = 1;
`else
        exp_w = 1; exp_r = 0;
`endif
        chk("t5_wren", wren_cnt - w0, exp_w);
        chk("t5_rom_block", rom_cnt - r0, exp_r);
        chk("t5_rom_with_ack", rom_orphan - o0, 0);
        cpu_we = 1'b0;
        run(3'b010, "t5r", b, c);
        chk("t5_readback", log_dat[b], exp_w ? 8'hFF : 8'h0A);

        // Reset while a DMA write sits in WAIT.
        dma_we = 1'b1; dma_addr = 16'h9ABC; dma_wdata = 8'h77;
        n0 = log_who.size();
        dma_req = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1; dma_req = 1'b0;
        @(posedge clk); #1;
        chk("t6_acks",  {vid_ack, cpu_ack, dma_ack}, 0);
        chk("t6_rdata", {vid_rdata, cpu_rdata, dma_rdata}, 0);
        chk("t6_mem",   {mem_address, mem_data, mem_wren, rom_block}, 0);
        rst = 1'b0;
        ref_mem[16'h9ABC] = 8'h77;  // the write strobe reached the RAM before reset
        rr_dma_m = 1'b0;
        @(posedge clk); #1;
        chk("t6_noack", log_who.size() - n0, 0);
        dma_we = 1'b0; dma_addr = 16'h4000; cpu_addr = 16'h9ABC;
        run(3'b110, "t6n", b, c);

        // Round-robin pointer returns to CPU on reset.
        run(3'b010, "rr_pre", b, c);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        rr_dma_m = 1'b0;
        run(3'b110, "rr_rst", b, c);
        chk("rr_rst_first", log_who[b], 1);

        // Randomized contention.
        for (int i = 0; i < 30; i++) begin
            logic [2:0] mask;
            mask = 3'($urandom_range(1, 7));
            vid_addr = rnd_addr();
            cpu_we = 1'($urandom); cpu_addr = rnd_addr(); cpu_wdata = 8'($urandom);
            dma_we = 1'($urandom); dma_addr = rnd_addr(); dma_wdata = 8'($urandom);
            run(mask, $sformatf("rnd%0d", i), b, c);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        chk("wren_single_cycle", wren_dbl, 0);
        chk("rom_block_with_ack", rom_orphan, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
